// File: rtl/serial_rx_deframer.sv
// serial_rx_deframer
//
// Recovers asynchronous start/stop framed characters from a serial line that
// is already synchronous to i_clk. The frame is 1 start bit, DATA_BITS data
// bits sent LSB first, then 1 stop bit. Each bit is sampled near its centre:
// HALF cycles after the start edge is seen, then once every CLKS_PER_BIT
// cycles after that.
//
// Parameters:
//   CLKS_PER_BIT  i_clk cycles per serial bit (2..65535)
//   DATA_BITS     data bits per character (5..8)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous reset, active low
//   i_in         synchronized serial line, idle/mark = 1
//   o_data       last good character, LSB = first received bit
//   o_valid      one-cycle strobe, o_data newly updated
//   o_frame_err  one-cycle strobe, stop bit sampled low
//   o_busy       frame in progress (START, DATA or STOP)
//   o_idle       IDLE state with the line currently high
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line at mark, waiting for a low level (start edge)
// S_START | timing to the middle of the start bit to confirm it
// S_DATA  | sampling DATA_BITS data bits at bit centres
// S_STOP  | sampling the stop bit; accept character or flag error
// S_BREAK | line held low after a framing error; wait for mark

module serial_rx_deframer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_in,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy,
    output logic                 o_idle
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);

    // Terminal counts: the counter restarts from 0 on every sample edge, so a
    // sample lands on the edge where it reaches (interval - 1).
    localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!i_in) begin
                        state  <= S_START;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_TC) begin
                        cnt <= '0;
                        if (i_in) begin
                            // Low pulse shorter than half a bit: not a start.
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt   <= '0;
                        shreg <= {i_in, shreg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        if (i_in) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= S_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_BREAK: begin
                    if (i_in) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Held low while reset is asserted so every output reads 0 in reset.
    assign o_idle = (state == S_IDLE) && i_in && i_reset;

endmodule

// File: tb/tb_serial_rx_deframer.sv
module tb_serial_rx_deframer;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int TS_OFS = CPB / 2 + (DB + 1) * CPB;   // 38
    localparam int FRAME  = (DB + 2) * CPB;             // 40

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line;
    logic [DB-1:0] data;
    logic          valid, ferr, busy, idle;

    serial_rx_deframer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_in       (line),
        .o_data     (data),
        .o_valid    (valid),
        .o_frame_err(ferr),
        .o_busy     (busy),
        .o_idle     (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // Strobe monitor, sampled on the falling edge.
    int   n_valid = 0, n_ferr = 0, n_both = 0;
    int   valid_cyc = 0, prev_valid_cyc = 0, ferr_cyc = 0;
    logic busy_at_valid = 1'b0, busy_before = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            n_valid++;
            prev_valid_cyc = valid_cyc;
            valid_cyc      = cyc;
            busy_at_valid  = busy;
            busy_before    = prev_busy;
        end
        if (ferr === 1'b1) begin
            n_ferr++;
            ferr_cyc = cyc;
        end
        if (valid === 1'b1 && ferr === 1'b1) n_both++;
        prev_busy = busy;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one full frame. t0 is the edge at which the start bit is first seen.
    task automatic send(input logic [7:0] d, input logic stop, output int t0);
        line = 1'b0;
        t0   = cyc + 1;
        repeat (CPB) step();
        for (int k = 0; k < DB; k++) begin
            line = d[k];
            repeat (CPB) step();
        end
        line = stop;
        repeat (CPB) step();
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        bit         exp_valid;
        bit         exp_ferr;
        logic [7:0] exp_data;
        bit         chk_b2b;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   t0, nv0, nf0;
        logic ok;

        vecs[0] = '{8'h55, 1'b1, 3, 1'b1, 1'b0, 8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 0, 1'b1, 1'b0, 8'hA3, 1'b0};
        vecs[2] = '{8'h0F, 1'b1, 3, 1'b1, 1'b0, 8'h0F, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 2, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 2, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'h96, 1'b0, 4, 1'b0, 1'b1, 8'hFF, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 2, 1'b1, 1'b0, 8'h7E, 1'b0};

        // Reset with the line idle.
        rst_n = 1'b0;
        line  = 1'b1;
        repeat (3) step();
        chk("rst_idle",  32'(idle),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr",  32'(ferr),  32'd0);
        chk("rst_data",  32'(data),  32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            nv0 = n_valid;
            nf0 = n_ferr;
            send(vecs[i].d, vecs[i].stop, t0);
            line = 1'b1;
            repeat (vecs[i].gap) step();
            chk($sformatf("v%0d_nvalid", i), 32'(n_valid - nv0), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_nferr", i),  32'(n_ferr - nf0),  32'(vecs[i].exp_ferr));
            chk($sformatf("v%0d_data", i),   32'(data),          32'(vecs[i].exp_data));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_valid_cyc", i), 32'(valid_cyc), 32'(t0 + TS_OFS));
                chk($sformatf("v%0d_busy_at_valid", i), 32'(busy_at_valid), 32'd0);
                chk($sformatf("v%0d_busy_before", i), 32'(busy_before), 32'd1);
            end
            if (vecs[i].exp_ferr)
                chk($sformatf("v%0d_ferr_cyc", i), 32'(ferr_cyc), 32'(t0 + TS_OFS));
            if (vecs[i].chk_b2b)
                chk($sformatf("v%0d_b2b_spacing", i), 32'(valid_cyc - prev_valid_cyc), 32'(FRAME));
        end

        // False start: one low cycle.
        nv0 = n_valid;
        nf0 = n_ferr;
        line = 1'b0;
        step();
        chk("fs_busy_t0", 32'(busy), 32'd1);
        line = 1'b1;
        step();
        chk("fs_idle_t1", 32'(idle), 32'd0);
        step();
        chk("fs_busy_t2", 32'(busy), 32'd0);
        chk("fs_idle_t2", 32'(idle), 32'd1);
        repeat (10) step();
        chk("fs_nvalid", 32'(n_valid - nv0), 32'd0);
        chk("fs_nferr",  32'(n_ferr - nf0),  32'd0);
        chk("fs_data",   32'(data),          32'h7E);

        // Stop bit low, then line held low (break).
        nv0 = n_valid;
        nf0 = n_ferr;
        send(8'h96, 1'b0, t0);
        ok = 1'b1;
        repeat (20) begin
            step();
            if (busy !== 1'b0 || idle !== 1'b0) ok = 1'b0;
        end
        chk("brk_busy_idle_low", 32'(ok), 32'd1);
        chk("brk_nferr",    32'(n_ferr - nf0),  32'd1);
        chk("brk_ferr_cyc", 32'(ferr_cyc),      32'(t0 + TS_OFS));
        chk("brk_nvalid",   32'(n_valid - nv0), 32'd0);
        chk("brk_data",     32'(data),          32'h7E);
        line = 1'b1;
        step();
        chk("brk_idle_high", 32'(idle), 32'd1);
        repeat (2) step();
        nv0 = n_valid;
        send(8'h3C, 1'b1, t0);
        line = 1'b1;
        repeat (3) step();
        chk("brk_next_data",   32'(data),          32'h3C);
        chk("brk_next_nvalid", 32'(n_valid - nv0), 32'd1);
        chk("brk_next_cyc",    32'(valid_cyc),     32'(t0 + TS_OFS));

        // Reset asserted during data bit 3.
        nv0 = n_valid;
        nf0 = n_ferr;
        line = 1'b0;
        repeat (CPB) step();
        for (int k = 0; k < 3; k++) begin
            line = (k == 0) ? 1'b1 : 1'b0;
            repeat (CPB) step();
        end
        line = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        line  = 1'b1;
        step();
        chk("mr_data",  32'(data),  32'd0);
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_ferr",  32'(ferr),  32'd0);
        chk("mr_busy",  32'(busy),  32'd0);
        chk("mr_idle",  32'(idle),  32'd0);
        rst_n = 1'b1;
        repeat (50) step();
        chk("mr_nvalid",    32'(n_valid - nv0), 32'd0);
        chk("mr_nferr",     32'(n_ferr - nf0),  32'd0);
        chk("mr_idle_after", 32'(idle),         32'd1);
        nv0 = n_valid;
        send(8'h81, 1'b1, t0);
        line = 1'b1;
        repeat (3) step();
        chk("mr_next_data",   32'(data),          32'h81);
        chk("mr_next_nvalid", 32'(n_valid - nv0), 32'd1);
        chk("mr_next_cyc",    32'(valid_cyc),     32'(t0 + TS_OFS));

        chk("never_both_strobes", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
